// File: rtl/btb_pkg.sv
// Shared front-end types: branch record carried from fetch to execute, PC width, BTB geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btb_pkg;

    localparam int PC_W = 32;

    // BTB geometry, shared with the BTB itself so indexing stays consistent.
    localparam int TAGW = 20;
    localparam int SETS = 64;

    // One in-flight predicted branch as captured at fetch.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_valid;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } br_rec_t;

endpackage

// File: rtl/branch_record_fifo.sv
// In-order circular buffer of branch records with flush.
// Latency: push visible at head one cycle after the write edge; head is read combinationally.
// Backpressure: push dropped while full, pop ignored while empty; flush clears everything incl. same-cycle push.
//
// Ports: clk/rst (sync active-high); push/push_rec enqueue; pop dequeues head;
// flush empties the buffer; head_rec is the oldest record; full/empty/count report occupancy.
module branch_record_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  br_rec_t                push_rec,
    input  logic                   pop,
    input  logic                   flush,
    output br_rec_t                head_rec,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    br_rec_t         mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     cnt;
    logic            push_acc;
    logic            pop_acc;

    assign full     = (cnt == (PW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign head_rec = mem[head];

    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) tail <= tail + 1'b1;
            if (pop_acc)  head <= head + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; a write during flush lands in a slot the reset pointers treat as free.
    always_ff @(posedge clk) begin
        if (push_acc) mem[tail] <= push_rec;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds predicted branches from fetch until execute resolves them; trains the BTB and redirects on mispredict.
// Latency: update/mispredict pulses and payload appear one cycle after the accepted resolve.
// Backpressure: push dropped while full, resolve ignored while empty; a mispredict flushes all wrong-path records.
//
// Ports: clk/rst (sync active-high); push_* enqueue a fetch prediction; full/empty/count occupancy;
// resolve_* give the actual outcome of the oldest branch; update_* drive the BTB write port;
// mispredict/redirect_pc steer the front end; mispredict_cnt is a saturating event counter.
module branch_resolve_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_en,
    input  logic [PC_W-1:0]        push_pc,
    input  logic                   push_pred_valid,
    input  logic                   push_pred_taken,
    input  logic [PC_W-1:0]        push_pred_target,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   resolve_en,
    input  logic                   resolve_taken,
    input  logic [PC_W-1:0]        resolve_target,
    output logic                   update_en,
    output logic [PC_W-1:0]        update_pc,
    output logic                   actual_taken,
    output logic [PC_W-1:0]        update_target,
    output logic                   mispredict,
    output logic [PC_W-1:0]        redirect_pc,
    output logic [15:0]            mispredict_cnt
);

    br_rec_t         push_rec;
    br_rec_t         head_rec;
    logic            resolve_acc;
    logic            pred_taken_eff;
    logic            mis_flag;
    logic            flush;
    logic [PC_W-1:0] redirect_nxt;

    assign push_rec = '{pc:          push_pc,
                        pred_valid:  push_pred_valid,
                        pred_taken:  push_pred_taken,
                        pred_target: push_pred_target};

    assign resolve_acc = resolve_en && !empty;

    // A BTB miss is an implicit not-taken prediction.
    assign pred_taken_eff = head_rec.pred_valid && head_rec.pred_taken;

    // Target only matters when both prediction and outcome are taken.
    always_comb begin
        mis_flag = 1'b0;
        if (resolve_taken != pred_taken_eff)
            mis_flag = 1'b1;
        else if (resolve_taken && (resolve_target != head_rec.pred_target))
            mis_flag = 1'b1;
    end

    assign flush        = resolve_acc && mis_flag;
    assign redirect_nxt = resolve_taken ? resolve_target : head_rec.pc + 32'd4;

    branch_record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_en),
        .push_rec (push_rec),
        .pop      (resolve_acc),
        .flush    (flush),
        .head_rec (head_rec),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Pulses last one cycle; payload registers hold until the next event of their kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            update_en      <= 1'b0;
            update_pc      <= '0;
            actual_taken   <= 1'b0;
            update_target  <= '0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            update_en  <= resolve_acc;
            mispredict <= flush;
            if (resolve_acc) begin
                update_pc     <= head_rec.pc;
                actual_taken  <= resolve_taken;
                update_target <= resolve_target;
            end
            if (flush) begin
                redirect_pc <= redirect_nxt;
                if (mispredict_cnt != 16'hFFFF)
                    mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized run vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolve_queue;
    import btb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_en;
    logic [31:0] push_pc;
    logic        push_pred_valid;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        resolve_en;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    int tests = 0;
    int fails = 0;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_en          (push_en),
        .push_pc          (push_pc),
        .push_pred_valid  (push_pred_valid),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .resolve_en       (resolve_en),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .actual_taken     (actual_taken),
        .update_target    (update_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        pv;
        logic        pt;
        logic [31:0] ptgt;
        logic        res;
        logic        rt;
        logic [31:0] rtgt;
        int          cnt;
        logic        upd;
        logic [31:0] upc;
        logic        mis;
        logic [31:0] redir;
        int          mcnt;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic p, logic [31:0] pc, logic pv, logic pt, logic [31:0] ptgt,
                                logic r, logic rt, logic [31:0] rtgt, int cnt,
                                logic upd, logic [31:0] upc, logic mis, logic [31:0] redir, int mcnt);
        vec_t v;
        v.push = p; v.pc = pc; v.pv = pv; v.pt = pt; v.ptgt = ptgt;
        v.res = r; v.rt = rt; v.rtgt = rtgt; v.cnt = cnt;
        v.upd = upd; v.upc = upc; v.mis = mis; v.redir = redir; v.mcnt = mcnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic [31:0] pc, input logic pv, input logic pt,
                         input logic [31:0] ptgt, input logic r, input logic rt, input logic [31:0] rtgt);
        push_en = p; push_pc = pc; push_pred_valid = pv; push_pred_taken = pt; push_pred_target = ptgt;
        resolve_en = r; resolve_taken = rt; resolve_target = rtgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_update_en"}, 32'(update_en), 32'd0);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        chk({tag, "_update_pc"}, update_pc, 32'd0);
        chk({tag, "_actual_taken"}, 32'(actual_taken), 32'd0);
        chk({tag, "_update_target"}, update_target, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'd0);
    endtask

    // Reference model state
    br_rec_t     mq[$];
    logic        m_upd, m_mis, m_at;
    logic [31:0] m_upc, m_utgt, m_redir;
    logic [15:0] m_mcnt;

    initial begin
        logic [31:0] last_upc;
        logic [31:0] last_utgt;
        logic [31:0] last_redir;
        logic        last_at;

        rst = 1'b1;
        idle();
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;

        // Directed vectors: correct prediction, direction mispredict with flush,
        // not-taken redirect wrap, full/empty limits, simultaneous push/resolve across wrap.
        tbl[0]  = mk(1, 32'h100, 1, 1, 32'h200, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h0, 0);
        tbl[1]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h200, 0, 1, 32'h100, 0, 32'h0, 0);
        tbl[2]  = mk(1, 32'h40,  0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h0, 0);
        tbl[3]  = mk(1, 32'h44,  1, 1, 32'h300, 0, 0, 32'h0,   2, 0, 32'h0, 0, 32'h0, 0);
        tbl[4]  = mk(1, 32'h48,  1, 0, 32'h0,   0, 0, 32'h0,   3, 0, 32'h0, 0, 32'h0, 0);
        tbl[5]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h80,  0, 1, 32'h40, 1, 32'h80, 1);
        tbl[6]  = mk(1, 32'hFFFFFFFC, 1, 1, 32'h1000, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1);
        tbl[7]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h1234, 0, 1, 32'hFFFFFFFC, 1, 32'h0, 2);
        tbl[8]  = mk(1, 32'h10,  1, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h0, 2);
        tbl[9]  = mk(1, 32'h14,  1, 0, 32'h0,   0, 0, 32'h0,   2, 0, 32'h0, 0, 32'h0, 2);
        tbl[10] = mk(1, 32'h18,  1, 0, 32'h0,   0, 0, 32'h0,   3, 0, 32'h0, 0, 32'h0, 2);
        tbl[11] = mk(1, 32'h1C,  1, 0, 32'h0,   0, 0, 32'h0,   4, 0, 32'h0, 0, 32'h0, 2);
        tbl[12] = mk(1, 32'h20,  1, 0, 32'h0,   0, 0, 32'h0,   4, 0, 32'h0, 0, 32'h0, 2);
        tbl[13] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h55,  3, 1, 32'h10, 0, 32'h0, 2);
        tbl[14] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h55,  2, 1, 32'h14, 0, 32'h0, 2);
        tbl[15] = mk(1, 32'h24,  1, 0, 32'h0,   1, 0, 32'h55,  2, 1, 32'h18, 0, 32'h0, 2);
        tbl[16] = mk(1, 32'h28,  1, 0, 32'h0,   1, 0, 32'h55,  2, 1, 32'h1C, 0, 32'h0, 2);
        tbl[17] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h55,  1, 1, 32'h24, 0, 32'h0, 2);
        tbl[18] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h55,  0, 1, 32'h28, 0, 32'h0, 2);
        tbl[19] = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h99,  0, 0, 32'h0, 0, 32'h0, 2);

        last_upc = 32'h0; last_utgt = 32'h0; last_redir = 32'h0; last_at = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].push, tbl[i].pc, tbl[i].pv, tbl[i].pt, tbl[i].ptgt,
                  tbl[i].res, tbl[i].rt, tbl[i].rtgt);
            step();
            if (tbl[i].upd) begin
                last_upc = tbl[i].upc; last_utgt = tbl[i].rtgt; last_at = tbl[i].rt;
            end
            if (tbl[i].mis) last_redir = tbl[i].redir;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("vec%0d_update_en", i), 32'(update_en), 32'(tbl[i].upd));
            chk($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].mis));
            chk($sformatf("vec%0d_update_pc", i), update_pc, last_upc);
            chk($sformatf("vec%0d_update_target", i), update_target, last_utgt);
            chk($sformatf("vec%0d_actual_taken", i), 32'(actual_taken), 32'(last_at));
            chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, last_redir);
            chk($sformatf("vec%0d_mispredict_cnt", i), 32'(mispredict_cnt), 32'(tbl[i].mcnt));
        end

        // Full queue: simultaneous push is rejected while the resolve still drains.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700 + 32'(i*4), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            step();
        end
        chk("full_fill_count", 32'(count), 32'd4);
        drive(1'b1, 32'h7F0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("full_pushres_count", 32'(count), 32'd3);
        chk("full_pushres_upc", update_pc, 32'h700);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            step();
            chk($sformatf("full_drain%0d_upc", i), update_pc, 32'h700 + 32'(i*4));
            chk($sformatf("full_drain%0d_mis", i), 32'(mispredict), 32'd0);
        end
        chk("full_drain_count", 32'(count), 32'd0);
        step();
        chk("full_empty_resolve_upd", 32'(update_en), 32'd0);

        // Reset mid-stream with a mispredicting resolve pending on the same edge.
        idle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(i*4), 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
            step();
        end
        chk("rstmid_count_before", 32'(count), 32'd3);
        drive(1'b1, 32'h5F0, 1'b1, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        chk_reset_state("rstmid");
        rst = 1'b0;
        idle();
        step();
        chk_reset_state("rstmid_after");

        // Randomized run against a queue model.
        mq.delete();
        m_upd = 0; m_mis = 0; m_at = 0; m_upc = 0; m_utgt = 0; m_redir = 0; m_mcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic    r_rst, r_push, r_res, r_rt, peff, mis, acc_push, acc_res;
            logic [31:0] r_tgt;
            br_rec_t nrec, h;
            r_rst  = ($urandom_range(99) == 0);
            r_push = ($urandom_range(99) < 55);
            r_res  = ($urandom_range(99) < 45);
            nrec.pc          = {$urandom_range(255), 2'b00};
            nrec.pred_valid  = $urandom_range(1);
            nrec.pred_taken  = $urandom_range(1);
            nrec.pred_target = {$urandom_range(255), 2'b00};
            r_rt  = $urandom_range(1);
            r_tgt = {$urandom_range(255), 2'b00};
            if (mq.size() > 0 && $urandom_range(99) < 70) begin
                r_rt  = mq[0].pred_valid && mq[0].pred_taken;
                r_tgt = mq[0].pred_target;
            end
            drive(r_push, nrec.pc, nrec.pred_valid, nrec.pred_taken, nrec.pred_target,
                  r_res, r_rt, r_tgt);
            rst = r_rst;

            if (r_rst) begin
                mq.delete();
                m_upd = 0; m_mis = 0; m_at = 0; m_upc = 0; m_utgt = 0; m_redir = 0; m_mcnt = 0;
            end else begin
                acc_push = r_push && (mq.size() < DEPTH);
                acc_res  = r_res && (mq.size() > 0);
                m_upd = acc_res;
                m_mis = 1'b0;
                if (acc_res) begin
                    h    = mq[0];
                    peff = h.pred_valid && h.pred_taken;
                    mis  = (r_rt != peff) || (r_rt && peff && (r_tgt != h.pred_target));
                    m_upc = h.pc; m_at = r_rt; m_utgt = r_tgt;
                    if (mis) begin
                        m_mis   = 1'b1;
                        m_redir = r_rt ? r_tgt : h.pc + 32'd4;
                        if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
                        mq.delete();
                        acc_push = 1'b0;
                    end else begin
                        void'(mq.pop_front());
                    end
                end
                if (acc_push) mq.push_back(nrec);
            end

            step();
            rst = 1'b0;
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
            chk("rnd_update_en", 32'(update_en), 32'(m_upd));
            chk("rnd_mispredict", 32'(mispredict), 32'(m_mis));
            chk("rnd_update_pc", update_pc, m_upc);
            chk("rnd_actual_taken", 32'(actual_taken), 32'(m_at));
            chk("rnd_update_target", update_target, m_utgt);
            chk("rnd_redirect_pc", redirect_pc, m_redir);
            chk("rnd_mispredict_cnt", 32'(mispredict_cnt), 32'(m_mcnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of in-flight branch records (power of two, 2..16).
REQ-002 SHALL have port `clk`, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst`, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port `push_en`, input, 1: fetch enqueues one predicted-branch record this cycle.
REQ-005 SHALL have port `push_pc`, input, 32: PC of the branch.
REQ-006 SHALL have port `push_pred_valid`, input, 1: BTB hit at fetch.
REQ-007 SHALL have port `push_pred_taken`, input, 1: predicted direction.
REQ-008 SHALL have port `push_pred_target`, input, 32: predicted next PC.
REQ-009 SHALL have port `full`, output, 1: queue holds DEPTH records.
REQ-010 SHALL have port `empty`, output, 1: queue holds 0 records.
REQ-011 SHALL have port `count`, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-012 SHALL have port `resolve_en`, input, 1: execute resolves the oldest branch.
REQ-013 SHALL have port `resolve_taken`, input, 1: actual direction.
REQ-014 SHALL have port `resolve_target`, input, 32: computed branch target.
REQ-015 SHALL have port `update_en`, output, 1: one-cycle pulse driving the BTB update port.
REQ-016 SHALL have port `update_pc`, output, 32: PC of the branch being trained.
REQ-017 SHALL have port `actual_taken`, output, 1: actual direction of the branch being trained.
REQ-018 SHALL have port `update_target`, output, 32: target of the branch being trained.
REQ-019 SHALL have port `mispredict`, output, 1: one-cycle pulse, front-end redirect required.
REQ-020 SHALL have port `redirect_pc`, output, 32: correct next PC, valid while `mispredict` is high.
REQ-021 SHALL have port `mispredict_cnt`, output, 16: saturating count of mispredictions.

Function
REQ-022 SHALL store records in an in-order circular buffer with head/tail pointers that wrap modulo DEPTH.
REQ-023 SHALL accept a push only when `push_en` is high and `full` is low; a push while full is dropped with no state change.
REQ-024 SHALL accept a resolve only when `resolve_en` is high and `empty` is low; a resolve while empty is ignored and no outputs pulse.
REQ-025 SHALL, on a simultaneous accepted push and resolve with no mispredict, perform both and leave `count` unchanged; when full, the push is still rejected that cycle.
REQ-026 SHALL compute, for the head record, the effective prediction as pred_taken_eff = pred_valid AND pred_taken.
REQ-027 SHALL flag a mispredict when resolve_taken differs from pred_taken_eff, or when both are taken and resolve_target differs from pred_target.
REQ-028 SHALL, one cycle after an accepted resolve, pulse `update_en` with: update_pc = record PC, actual_taken = resolve_taken, update_target = resolve_target.
REQ-029 SHALL, when the flag is set, pulse `mispredict` in the same cycle as `update_en`.
REQ-030 SHALL drive redirect_pc = resolve_target if taken, else record PC + 4, with 32-bit wrap.
REQ-031 SHALL, on a mispredicting resolve, discard every remaining (wrong-path) record plus any same-cycle push at that edge, leaving count = 0 and empty = 1.
REQ-032 SHALL increment `mispredict_cnt` on each mispredict, saturating at 16'hFFFF.
REQ-033 SHALL register `update_en`, `mispredict`, and all payload outputs; when no pulse is active they hold their last values.

Reset
REQ-034 SHALL, while `rst` is high at a clock edge, clear the pointers; reset values: count = 0, empty = 1, full = 0, update_en = 0, mispredict = 0, update_pc = 0, actual_taken = 0, update_target = 0, redirect_pc = 0, mispredict_cnt = 0.
REQ-035 SHALL give `rst` priority over simultaneous push/resolve; reset mid-operation discards all records and any pending pulse.

Structure
REQ-036 SHALL place the branch-record struct (pc, pred_valid, pred_taken, pred_target) and PC width constant in shared package btb_pkg, alongside the BTB's TAGW/SETS constants.
REQ-037 SHALL use one sub-module, branch_record_fifo (storage, pointers, count, flush input); compare/update logic stays in the top.

Verification
REQ-038 SHALL verify correct prediction: push pc=0x100, pred_valid=1, pred_taken=1, pred_target=0x200; resolve taken with target 0x200 -> next cycle update_en=1, update_pc=0x100, update_target=0x200; mispredict=0; count=0.
REQ-039 SHALL verify direction mispredict with flush: push 3 records, first with pred_valid=0 at pc=0x40; resolve taken with target 0x80 -> mispredict=1, redirect_pc=0x80, count=0, mispredict_cnt=1.
REQ-040 SHALL verify not-taken redirect: record pc=0xFFFFFFFC predicted taken; resolve not-taken -> redirect_pc=0x00000000.
REQ-041 SHALL verify full/empty boundaries: 5 pushes with DEPTH=4 -> count=4, full=1, 5th dropped; resolve with empty=1 -> no update_en.
REQ-042 SHALL verify simultaneous push/resolve at count=2 with correct prediction -> count stays 2; records drain in order across pointer wrap.
REQ-043 SHALL verify reset mid-stream: assert rst with 3 records and a resolve pending -> all outputs at reset values next cycle; the pending pulse is suppressed.
